// File: rtl/fifo_param_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_param_ctrl: parametrised synchronous FIFO with push/pop interface,
// programmable almost-full/almost-empty thresholds and a sticky error flag.
// Revision: 1.0
// ============================================================================
module fifo_param_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   almost_full_thr,
  input  logic [ADDR_WIDTH:0]   almost_empty_thr,
  output logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;

  // A pop frees a slot in the same edge, so a full FIFO still takes a push
  // when it is paired with an accepted pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign full         = (fifo_count == DEPTH_CNT);
  assign empty        = (fifo_count == '0);
  assign almost_full  = (fifo_count >= almost_full_thr);
  assign almost_empty = (fifo_count <= almost_empty_thr);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      fifo_data_out <= '0;
      valid_out     <= 1'b0;
      error         <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (pop_ok) begin
        fifo_data_out <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if ((push & ~push_ok) | (pop & ~pop_ok)) begin
        error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_param_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_param_ctrl: scoreboard bench for fifo_param_ctrl with a queue-based
// reference model, directed scenarios followed by randomized traffic.
// Revision: 1.0
// ============================================================================
module tb_fifo_param_ctrl;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] fifo_data_in = '0;
  logic          push = 1'b1;
  logic          pop = 1'b1;
  logic [AW:0]   af_thr = 4'(DEPTH);
  logic [AW:0]   ae_thr = '0;
  logic [DW-1:0] fifo_data_out;
  logic          valid_out;
  logic [AW:0]   fifo_count;
  logic          full, empty, almost_full, almost_empty, error;

  fifo_param_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_data_in     (fifo_data_in),
    .push             (push),
    .pop              (pop),
    .almost_full_thr  (af_thr),
    .almost_empty_thr (ae_thr),
    .fifo_data_out    (fifo_data_out),
    .valid_out        (valid_out),
    .fifo_count       (fifo_count),
    .full             (full),
    .empty            (empty),
    .almost_full      (almost_full),
    .almost_empty     (almost_empty),
    .error            (error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stored words as a queue, plus sticky error and last output.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] exp_q [$];
  logic          m_err = 1'b0;
  logic [DW-1:0] m_out = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int cnt;
    cnt = mq.size();
    chk("fifo_count", 32'(fifo_count), 32'(cnt));
    chk("full", 32'(full), 32'(cnt == DEPTH));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("almost_full", 32'(almost_full), 32'(cnt >= int'(af_thr)));
    chk("almost_empty", 32'(almost_empty), 32'(cnt <= int'(ae_thr)));
    chk("error", 32'(error), 32'(m_err));
    chk("data_hold", 32'(fifo_data_out), 32'(m_out));
  endtask

  task automatic model_step(input logic rs, input logic ps, input logic pp, input logic [DW-1:0] d);
    bit can_pop, can_push;
    if (rs) begin
      mq.delete();
      m_err = 1'b0;
      m_out = '0;
    end else begin
      can_pop  = pp && (mq.size() > 0);
      can_push = ps && ((mq.size() < DEPTH) || can_pop);
      if (pp && !can_pop)  m_err = 1'b1;
      if (ps && !can_push) m_err = 1'b1;
      if (can_pop) begin
        m_out = mq.pop_front();
        exp_q.push_back(m_out);
      end
      if (can_push) mq.push_back(d);
    end
  endtask

  // Thresholds are applied first so the flag checks see their immediate effect.
  task automatic cycle(input logic rs, input logic ps, input logic pp, input logic [DW-1:0] d,
                       input logic [AW:0] af, input logic [AW:0] ae);
    @(negedge clk);
    af_thr = af;
    ae_thr = ae;
    #1;
    check_state();
    reset = rs; push = ps; pop = pp; fifo_data_in = d;
    model_step(rs, ps, pp, d);
  endtask

  task automatic op(input logic rs, input logic ps, input logic pp, input logic [DW-1:0] d);
    cycle(rs, ps, pp, d, af_thr, ae_thr);
  endtask

  // Monitor: sample just after each edge and retire scoreboard entries.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      chk("valid_out", 32'(valid_out), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (valid_out === 1'b1) chk("pop_data", 32'(fifo_data_out), 32'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    bit rs, ps, pp;
    int pp_bias;

    // Reset held with push/pop active.
    op(1, 1, 1, 10'h155);
    op(1, 1, 1, 10'h155);
    op(0, 0, 0, '0);

    // Basic push then pop with one-cycle read latency.
    op(0, 1, 0, 10'h091);
    op(0, 1, 0, 10'h04A);
    op(0, 1, 0, 10'h093);
    op(0, 0, 0, '0);
    op(0, 0, 1, '0);
    op(0, 0, 0, '0);
    op(1, 0, 0, '0);

    // Fill, overflow, drain.
    for (int i = 1; i <= 8; i++) op(0, 1, 0, DW'(i));
    op(0, 1, 0, 10'h3FF);
    for (int i = 0; i < 8; i++) op(0, 0, 1, '0);
    op(0, 0, 0, '0);
    op(1, 0, 0, '0);

    // Full with simultaneous push/pop, then drain across the pointer wrap.
    for (int i = 1; i <= 8; i++) op(0, 1, 0, DW'(i));
    for (int i = 0; i < 3; i++) op(0, 1, 1, 10'h2AA);
    for (int i = 0; i < 8; i++) op(0, 0, 1, '0);
    op(0, 0, 0, '0);
    op(1, 0, 0, '0);

    // Programmable thresholds, including a live change.
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, DW'(10'h100 + i), 4'd6, 4'd2);
    cycle(0, 0, 0, '0, 4'd6, 4'd2);
    cycle(0, 0, 0, '0, 4'd8, 4'd2);
    cycle(0, 0, 0, '0, 4'd0, 4'd8);
    cycle(1, 0, 0, '0, 4'd8, 4'd0);

    // Underflow, push+pop on empty, mid-fill reset.
    op(0, 0, 1, '0);
    op(0, 0, 0, '0);
    op(1, 0, 0, '0);
    op(0, 1, 1, 10'h0C3);
    op(0, 0, 0, '0);
    op(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) op(0, 1, 0, DW'(10'h200 + i));
    op(1, 1, 1, 10'h3C3);
    op(0, 0, 0, '0);

    // Randomized traffic with shifting pop bias and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) pp_bias = int'($urandom_range(10, 90));
      rs = ($urandom_range(0, 199) == 0);
      ps = ($urandom_range(0, 99) >= pp_bias);
      pp = ($urandom_range(0, 99) < pp_bias);
      d  = DW'($urandom);
      cycle(rs, ps, pp, d, (AW + 1)'($urandom_range(0, 15)), (AW + 1)'($urandom_range(0, 15)));
    end

    op(0, 0, 0, '0);
    op(0, 0, 0, '0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
